// File: rtl/iob_skid_buf_pkg.sv
// Shared encodings for the two-entry skid buffer: FSM state codes and occupancy width.
package iob_skid_buf_pkg;

  localparam int ST_W    = 2;
  localparam int LEVEL_W = 2;

  localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [ST_W-1:0] ST_BUSY  = 2'd1;
  localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/iob_r.sv
// Enabled data register with a parameterised reset value.
// Latency one cycle from en_i to data_o; no handshake, holds while en_i is low.
module iob_r #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o <= RST_VAL;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_skid_buf.sv
// Two-entry elastic stage with fully registered s_ready_o/m_valid_o/m_data_o.
// Latency one cycle; absorbs one beat of back-pressure and drops s_ready_o only when both entries are held.
module iob_skid_buf
  import iob_skid_buf_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               rst_i,
  input  logic               s_valid_i,
  input  logic [DATA_W-1:0]  s_data_i,
  output logic               s_ready_o,
  output logic               m_valid_o,
  output logic [DATA_W-1:0]  m_data_o,
  input  logic               m_ready_i,
  output logic [LEVEL_W-1:0] level_o
);

  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_d;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_en;
  logic              main_sel_skid;
  logic              skid_en;
  logic              main_ld;
  logic              skid_ld;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic [DATA_W-1:0] skid_q;

  assign in_xfer  = s_valid_i & s_ready_o;
  assign out_xfer = m_valid_o & m_ready_i;

  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    main_sel_skid = 1'b0;
    skid_en       = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_en = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        case ({in_xfer, out_xfer})
          2'b11: main_en = 1'b1;
          2'b10: begin
            skid_en = 1'b1;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;
          default: state_d = ST_BUSY;
        endcase
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_en       = 1'b1;
          main_sel_skid = 1'b1;
          state_d       = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_EMPTY;
    end else if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over any handshake by forcing both registers to their reset value.
  assign main_ld = rst_i | main_en;
  assign skid_ld = rst_i | skid_en;
  assign main_d  = rst_i ? RST_VAL : (main_sel_skid ? skid_q : s_data_i);
  assign skid_d  = rst_i ? RST_VAL : s_data_i;

  iob_r #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_main_r (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (main_ld),
    .data_i (main_d),
    .data_o (m_data_o)
  );

  iob_r #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_skid_r (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (skid_ld),
    .data_i (skid_d),
    .data_o (skid_q)
  );

  assign s_ready_o = (state_q == ST_EMPTY) || (state_q == ST_BUSY);
  assign m_valid_o = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign level_o   = (state_q == ST_FULL) ? LEVEL_W'(2) :
                     (state_q == ST_BUSY) ? LEVEL_W'(1) : LEVEL_W'(0);

endmodule
